// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// State encodings, error codes and default handshake timeouts.
package uart_tx_sched_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StLaunch    = 3'd1,
    StWaitStart = 3'd2,
    StWaitDone  = 3'd3,
    StAck       = 3'd4,
    StError     = 3'd5
  } state_e;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrStartTo = 2'b01;
  localparam logic [1:0] ErrFrameTo = 2'b10;
  localparam logic [1:0] ErrTxFault = 2'b11;

  // Generous compared with the transmitter's edge-detect plus flag-set latency (a few clocks).
  localparam logic [15:0] DefStartTo = 16'h0100;
  localparam logic [19:0] DefFrameTo = 20'hFFFFF;

  function automatic logic [2:0] next_idx(input logic [2:0] idx, input int unsigned n);
    if (32'(idx) + 32'd1 >= n) return 3'd0;
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester, transmitter and status signals of the UART transmit scheduler.
// The scheduler uses the master modport; the surrounding logic uses slave.
interface uart_tx_sched_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic [15:0]       tx_data;
  logic              tx_sd_en;
  logic              tx_flag;
  logic              tx_ft;
  logic              busy;
  logic [2:0]        grant_id;
  logic              err;
  logic [1:0]        err_code;
  logic              err_clr;

  modport master (
    input  req, req_data, tx_flag, tx_ft, err_clr,
    output ack, tx_data, tx_sd_en, busy, grant_id, err, err_code
  );

  modport slave (
    output req, req_data, tx_flag, tx_ft, err_clr,
    input  ack, tx_data, tx_sd_en, busy, grant_id, err, err_code
  );
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, cyclically.
module uart_tx_sched_rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [2:0]      ptr_i,
  output logic            grant_valid_o,
  output logic [2:0]      grant_idx_o
);
  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IdxW-1:0] idx;

  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    idx           = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IdxW'((32'(ptr_i) + k) % NREQ);
      if (!grant_valid_o && req_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = 3'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between NREQ byte producers: round-robin grant,
// one-cycle send pulse, busy-flag tracking, ack on completion, timeout/fault reporting.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter logic [15:0] START_TO = DefStartTo,
  parameter logic [19:0] FRAME_TO = DefFrameTo
) (
  input logic             clk,
  input logic             rst,
  uart_tx_sched_if.master bus
);
  localparam logic [19:0] StartLim = {4'h0, START_TO} - 20'd1;
  localparam logic [19:0] FrameLim = FRAME_TO - 20'd1;

  state_e          state_q, state_d;
  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic [19:0]     timer_q, timer_d, timer_inc;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [15:0]     tx_data_q, tx_data_d;
  logic            sd_en_q, sd_en_d;
  logic            busy_q, busy_d;
  logic [2:0]      grant_q, grant_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;

  logic            grant_valid;
  logic [2:0]      grant_idx;
  logic [7:0]      sel_byte;

  uart_tx_sched_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req_i         (bus.req),
    .ptr_i         (rr_ptr_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  always_comb begin
    sel_byte = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_idx == 3'(i)) sel_byte = bus.req_data[8*i +: 8];
    end
  end

  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 20'd1;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    timer_d    = timer_q;
    ack_d      = '0;
    tx_data_d  = tx_data_q;
    sd_en_d    = 1'b0;
    grant_d    = grant_q;
    err_code_d = err_code_q;

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (grant_valid) begin
          grant_d   = grant_idx;
          tx_data_d = {8'h00, sel_byte};
          sd_en_d   = 1'b1;
          state_d   = StLaunch;
        end
      end
      StLaunch: begin
        timer_d = '0;
        state_d = StWaitStart;
      end
      StWaitStart: begin
        timer_d = timer_inc;
        // A transmitter fault outranks either timeout.
        if (!bus.tx_ft) begin
          state_d    = StError;
          err_code_d = ErrTxFault;
        end else if (bus.tx_flag) begin
          state_d = StWaitDone;
          timer_d = '0;
        end else if (timer_q == StartLim) begin
          state_d    = StError;
          err_code_d = ErrStartTo;
        end
      end
      StWaitDone: begin
        timer_d = timer_inc;
        if (!bus.tx_ft) begin
          state_d    = StError;
          err_code_d = ErrTxFault;
        end else if (!bus.tx_flag) begin
          state_d = StAck;
          ack_d   = NREQ'(1) << grant_q;
        end else if (timer_q == FrameLim) begin
          state_d    = StError;
          err_code_d = ErrFrameTo;
        end
      end
      StAck: begin
        rr_ptr_d = next_idx(grant_q, NREQ);
        state_d  = StIdle;
      end
      StError: begin
        if (bus.err_clr) begin
          if (!bus.tx_ft) begin
            err_code_d = ErrTxFault;
          end else begin
            err_code_d = ErrNone;
            rr_ptr_d   = next_idx(grant_q, NREQ);
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign err_d  = (state_d == StError);
  assign busy_d = (state_d != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      timer_q    <= '0;
      ack_q      <= '0;
      tx_data_q  <= '0;
      sd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      grant_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      timer_q    <= timer_d;
      ack_q      <= ack_d;
      tx_data_q  <= tx_data_d;
      sd_en_q    <= sd_en_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_sd_en = sd_en_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;

endmodule
